lc3_regfile_sb: RTL
===================

Name: lc3_regfile_sb

Overview:
- Parametrised successor to the LC-3 general-purpose register file, for the pipelined datapath.
- Two asynchronous read ports, one writeback port, a per-register scoreboard (busy bits) for RAW/WAW hazard detection, and an NZP condition-code register updated from writeback data.
- Sits between decode/issue, which reserves destination registers, and writeback, which retires results.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, do not override.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-low reset.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data; combinational.
- rd1_busy  out  1  register at rd1_addr has a pending write.
- rd2_addr  in  ADDR_W  read port 2 address.
- rd2_data  out  DATA_W  read port 2 data; combinational.
- rd2_busy  out  1  register at rd2_addr has a pending write.
- iss_valid  in  1  issue stage requests reservation of iss_dr.
- iss_dr  in  ADDR_W  destination register to reserve.
- iss_ready  out  1  reservation accepted this cycle.
- wb_valid  in  1  writeback strobe.
- wb_dr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- wb_cc_ld  in  1  update NZP from wb_data (qualified by wb_valid).
- sb_clr  in  1  synchronous flush of all busy bits.
- nzp  out  3  condition codes {N,Z,P}.
- sb_err  out  1  sticky: writeback to a non-busy register observed.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, nzp=3'b010, sb_err=0. rd*_data then reads 0 and rd*_busy reads 0.
- Reset asserted mid-operation discards every reservation. A writeback arriving after reset writes normally and sets sb_err. The pipeline flushes together with reset.
- Reads: rd*_data = reg[rd*_addr] with zero latency. rd*_busy = busy[rd*_addr].
- Issue handshake:
  - iss_ready = !busy[iss_dr] || (wb_valid && wb_dr==iss_dr).
  - Fire = iss_valid && iss_ready. Fire sets busy[iss_dr] on the next edge.
  - When fire coincides with writeback to the same register, busy stays 1 (the new reservation wins). The data is still written.
  - iss_ready does not depend on iss_valid (no combinational loop on valid).
- Writeback:
  - With wb_valid, reg[wb_dr] <= wb_data.
  - busy[wb_dr] <= 0 unless re-reserved in the same cycle.
  - If busy[wb_dr] was 0 and no same-cycle fire targets it, sb_err <= 1 (sticky until reset). The write still occurs.
- NZP: when wb_valid && wb_cc_ld, nzp <= N if wb_data[DATA_W-1], Z if wb_data==0, else P. Exactly one bit is set at all times.
- sb_clr:
  - Clears every busy bit on the next edge.
  - Has priority over a same-cycle issue set: a fire during sb_clr is dropped and iss_ready is forced to 0 that cycle.
  - A writeback in the same cycle still writes data; sb_err is not set for it.
- Simultaneous reads of the register being written return the old value, unless the optional bypass is built in.
- Any address is in range, because NUM_REGS is a power of two.

Optional Feature:
- Macro: LC3_RF_BYPASS_EN.
- Defined: when wb_valid and rd*_addr==wb_dr, rd*_data = wb_data and rd*_busy = 0 in that same cycle. Ports 1 and 2 are bypassed independently.
- Undefined: reads return the stored value, and busy deasserts one cycle after writeback.

Decomposition:
- Package lc3_rf_pkg holds:
  - DATA_W default;
  - NZP encodings (NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001);
  - reset constants.
- Sub-module lc3_scoreboard (NUM_REGS busy vector, issue/clear/flush logic, sb_err) is natural. The data array and NZP logic stay in the top module.

Test Plan:
- Reset then read all addresses -> rd1_data=0, rd2_data=0, busy=0, nzp=3'b010, sb_err=0.
- Issue R3 (iss_ready=1); re-issue R3 next cycle -> iss_ready=0. Writeback R3=16'h1234 with wb_cc_ld -> busy[3] clears next cycle, rd1 of R3 reads 16'h1234, nzp=3'b001.
- Writeback of 16'h8000 to busy R5 with wb_cc_ld -> nzp=3'b100. Writeback of 0 -> nzp=3'b010.
- Same-cycle issue R2 and writeback R2 (R2 busy) -> iss_ready=1, data written, busy[2] remains 1. Writeback to non-busy R6 -> sb_err=1 and stays 1.
- Reserve R1 and R4, then pulse sb_clr together with iss_valid for R7 -> all busy 0, R7 not reserved. Assert rst mid-stream -> immediate clear, nzp=3'b010.
- With LC3_RF_BYPASS_EN: rd1_addr=wb_dr=R0, wb_data=16'hBEEF -> rd1_data=16'hBEEF in the same cycle. Without the macro, rd1_data shows the old value until the next edge.

Source files
------------

// File: rtl/lc3_rf_pkg.sv
// Shared constants for the LC-3 register file with scoreboard.
package lc3_rf_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   typedef logic [2:0] nzp_t;

   localparam nzp_t NZP_N = 3'b100;
   localparam nzp_t NZP_Z = 3'b010;
   localparam nzp_t NZP_P = 3'b001;

   localparam nzp_t NZP_RST    = NZP_Z;
   localparam logic SB_ERR_RST = 1'b0;

endpackage

// File: rtl/lc3_scoreboard.sv
// Busy-bit scoreboard: issue reservation, writeback release, flush and sticky error.
module lc3_scoreboard
   import lc3_rf_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_valid,
   input  logic [ADDR_W-1:0]   iss_dr,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_dr,
   input  logic                sb_clr,
   output logic [NUM_REGS-1:0] busy,
   output logic                iss_ready,
   output logic                sb_err
);

   logic                fire;
   logic                same_dr_fire;
   logic                err_set;
   logic [NUM_REGS-1:0] busy_nxt;

   // A busy destination may still be reserved if it retires this same cycle.
   assign iss_ready    = !sb_clr && (!busy[iss_dr] || (wb_valid && (wb_dr == iss_dr)));
   assign fire         = iss_valid && iss_ready;
   assign same_dr_fire = fire && (iss_dr == wb_dr);
   assign err_set      = wb_valid && !sb_clr && !busy[wb_dr] && !same_dr_fire;

   always_comb begin
      busy_nxt = busy;
      if (sb_clr) begin
         busy_nxt = '0;
      end else begin
         if (wb_valid) busy_nxt[wb_dr] = 1'b0;
         // Applied after the release so a same-register reservation wins.
         if (fire) busy_nxt[iss_dr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy   <= '0;
         sb_err <= SB_ERR_RST;
      end else begin
         busy <= busy_nxt;
         if (err_set) sb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with busy scoreboard and NZP codes.
// Optional same-cycle writeback-to-read bypass: define LC3_RF_BYPASS_EN.
module lc3_regfile_sb
   import lc3_rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_busy,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd2_data,
   output logic              rd2_busy,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_dr,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_dr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_cc_ld,
   input  logic              sb_clr,
   output logic [2:0]        nzp,
   output logic              sb_err
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   nzp_t                nzp_nxt;

   lc3_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_dr    (iss_dr),
      .wb_valid  (wb_valid),
      .wb_dr     (wb_dr),
      .sb_clr    (sb_clr),
      .busy      (busy),
      .iss_ready (iss_ready),
      .sb_err    (sb_err)
   );

`ifdef LC3_RF_BYPASS_EN
   logic byp1;
   logic byp2;

   assign byp1     = wb_valid && (rd1_addr == wb_dr);
   assign byp2     = wb_valid && (rd2_addr == wb_dr);
   assign rd1_data = byp1 ? wb_data : regs[rd1_addr];
   assign rd2_data = byp2 ? wb_data : regs[rd2_addr];
   assign rd1_busy = !byp1 && busy[rd1_addr];
   assign rd2_busy = !byp2 && busy[rd2_addr];
`else
   assign rd1_data = regs[rd1_addr];
   assign rd2_data = regs[rd2_addr];
   assign rd1_busy = busy[rd1_addr];
   assign rd2_busy = busy[rd2_addr];
`endif

   always_comb begin
      nzp_nxt = NZP_P;
      if (wb_data[DATA_W-1])  nzp_nxt = NZP_N;
      else if (wb_data == '0) nzp_nxt = NZP_Z;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs <= '{default: '0};
         nzp  <= NZP_RST;
      end else if (wb_valid) begin
         regs[wb_dr] <= wb_data;
         if (wb_cc_ld) nzp <= nzp_nxt;
      end
   end

endmodule
